mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequencer and two-port arbiter for the 3-stage pipelined 4x4 multiplier. It accepts operand pairs from two requesters over valid/ready handshakes and arbitrates between them round-robin. It drives the multiplier's operand inputs and its `inEnable`/`sEnable`/`outEnable` stage enables, and tracks per-stage valid bits and requester IDs. Each product is returned on one shared result port, tagged with its originator. It sits between client logic and the multiplier instance and owns all of the multiplier's enable sequencing.

## Interface
- `DW`, 4, operand width; product width is `2*DW`. Only 4 is supported by the current multiplier.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operand pair.
- `req0_ready` / `req1_ready`  out  1  pair accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DW  operands.
- `mul_a`, `mul_b`  out  DW  to the multiplier's `aD`/`bD`.
- `mul_in_en`, `mul_s_en`, `mul_out_en`  out  1  to `inEnable`/`sEnable`/`outEnable`.
- `mul_p`  in  2*DW  from the multiplier's `pQ`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  2*DW  product; equals `mul_p`.
- `res_id`  out  1  originating requester.
- `busy`  out  1  any pipeline stage is valid.

## Operation
- State:
  - valid bits `v_in`, `v_s`, `v_out` and ID bits `id_in`, `id_s`, `id_out`, mirroring the multiplier's input, stage and output registers.
  - round-robin pointer `prio`, which names the requester that wins a tie.
- Advance rule: `adv = !v_out | res_ready`. If `adv` is 0 the whole pipe stalls: all three enables are 0 and all valid and ID bits hold.
- Grant:
  - combinational from `req*_valid` and `prio`.
  - a lone requester always wins.
  - on a tie the `prio` requester wins; `prio` then flips to the other requester.
  - `prio` updates only on an accepted handshake.
- `reqN_ready = adv & grant==N`. Ready may depend combinationally on `res_ready`. A requester must not gate its valid on ready.
- `mul_a`/`mul_b` carry the granted requester's operands. With no grant they carry the last granted operands, which are don't-care.
- Enables, when `adv` is 1:
  - `mul_in_en = 1` when any grant is made.
  - `mul_s_en = v_in`.
  - `mul_out_en = v_s`.
- Valid and ID shift on `adv`:
  - `v_in <= grant_any`.
  - `v_s <= v_in`.
  - `v_out <= v_s`.
  - IDs shift alongside their valid bits.
- Results: `res_valid = v_out`, `res_id = id_out`, `res_data = mul_p`. A result is consumed when `res_valid & res_ready`.
- Arithmetic: the product is unsigned and exact in `2*DW` bits; the maximum is 15*15 = 225.
- `busy = v_in | v_s | v_out`.

## Timing
- Reset (`rst` low, asynchronous):
  - all valid bits 0, `prio` = 0, ID bits 0.
  - outputs: `req*_ready` 0, all enables 0, `res_valid` 0, `busy` 0; `mul_a`/`mul_b` 0.
  - The controller does not drive the multiplier's reset.
  - Reset mid-operation discards every in-flight op; no stale result is ever presented afterwards.
- Latency: an accept at edge T loads the operands (`mul_in_en`) at T; `mul_s_en` fires at T+1 and `mul_out_en` at T+2. `res_valid` is high after T+2, so latency is 3 cycles.
- Throughput is one op per cycle while `res_ready` stays high.
- Stall: while `res_valid & !res_ready`, the pipe holds and `res_data`, `res_id` and `res_valid` stay stable.
- Consume and refill in the same cycle is legal: if `v_out & res_ready & v_s`, the next result loads at that edge with no bubble.
- If neither requester is valid, a bubble enters the pipe; the pipe still drains while `adv` is 1.

## Configuration
- `MULT_SEQ_CTRL_FIXED_PRIO_EN`:
  - defined: fixed priority; requester 0 always wins a tie, and `prio` is not implemented.
  - undefined (default): round-robin as described above.

## Structure
- Package `mult_seq_ctrl_pkg`:
  - `MULT_DW` = 4.
  - `MULT_STAGES` = 3.
  - typedef `req_id_t` (1 bit).
  - typedef `stage_t` (valid + ID).
- Sub-module `rr_arb2`:
  - a 2-request arbiter with registered `prio`, advanced by a grant-accept strobe.
  - the fixed-priority variant is selected inside it by the macro.

## Test plan
- Single op: req0 3×5 accepted at edge T → `res_valid` after T+2, `res_data` = 15, `res_id` = 0; enables fire at T, T+1, T+2 respectively.
- Contention: both requesters continuously valid with `res_ready` = 1 → grants alternate 0,1,0,1; results are back-to-back with IDs alternating; ops per requester within 1 of each other.
- Backpressure: full pipe, `res_ready` low for 4 cycles → all enables 0, `res_data` and `res_id` stable, both readies 0; after release, results continue in order with no loss or duplication.
- Extremes: 15×15 = 225, 0×9 = 0, 1×15 = 15, 8×2 = 16 → all exact.
- Reset mid-flight: two ops in flight, `rst` pulsed low for 1 cycle → `res_valid`, `busy`, readies and enables 0 immediately; no result emerges afterwards; the next request completes normally.
- Macro defined: both requesters continuously valid → every grant goes to requester 0 until it drops valid.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the 4x4 pipelined-multiplier sequencer.
// Imported by rr_arb2 and mult_seq_ctrl.
package mult_seq_ctrl_pkg;

  localparam int MULT_DW     = 4;
  localparam int MULT_STAGES = 3;

  typedef logic req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{v: 1'b0, id: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter with a registered round-robin pointer advanced on accept.
// Define MULT_SEQ_CTRL_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module rr_arb2
  import mult_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

`ifdef MULT_SEQ_CTRL_FIXED_PRIO_EN

  logic unused_ok;
  assign unused_ok = ^{clk, rst, accept};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end

`else

  req_id_t prio;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prio <= 1'b0;
    else if (accept) prio <= ~gnt_id;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    gnt = req;
    if (&req) gnt = prio ? 2'b10 : 2'b01;
  end

`endif

  assign gnt_id = gnt[1];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer/arbiter for the 3-stage 4x4 multiplier: grants one of two requesters,
// drives stage enables, tracks per-stage valid/ID. Option: MULT_SEQ_CTRL_FIXED_PRIO_EN.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int DW = MULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          mul_in_en,
  output logic          mul_s_en,
  output logic          mul_out_en,
  input  logic [2*DW-1:0] mul_p,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [2*DW-1:0] res_data,
  output logic          res_id,
  output logic          busy
);

  // pipe[0] mirrors the multiplier's input regs, pipe[1] its stage, pipe[2] its output.
  stage_t pipe [MULT_STAGES];

  logic       adv;
  logic       grant_any;
  logic       accept;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  req_id_t    gnt_id;
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;

  // Requests are masked while reset is asserted so no ready or load enable escapes.
  assign arb_req = {req1_valid & rst, req0_valid & rst};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign adv       = !pipe[MULT_STAGES-1].v | res_ready;
  assign grant_any = |gnt;
  assign accept    = adv & grant_any;

  assign req0_ready = adv & gnt[0];
  assign req1_ready = adv & gnt[1];

  assign mul_in_en  = accept;
  assign mul_s_en   = adv & pipe[0].v;
  assign mul_out_en = adv & pipe[1].v;

  always_comb begin
    mul_a = last_a;
    mul_b = last_b;
    if (gnt[0]) begin
      mul_a = req0_a;
      mul_b = req0_b;
    end else if (gnt[1]) begin
      mul_a = req1_a;
      mul_b = req1_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_a <= '0;
      last_b <= '0;
    end else if (accept) begin
      last_a <= mul_a;
      last_b <= mul_b;
    end
  end

  // The whole pipe shifts together on adv and freezes otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULT_STAGES; i++) pipe[i] <= STAGE_EMPTY;
    end else if (adv) begin
      pipe[0] <= '{v: grant_any, id: gnt_id};
      for (int i = 1; i < MULT_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign res_valid = pipe[MULT_STAGES-1].v;
  assign res_id    = pipe[MULT_STAGES-1].id;
  assign res_data  = mul_p;
  assign busy      = pipe[0].v | pipe[1].v | pipe[2].v;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 3-stage 4x4 multiplier attached.
module tb_mult_seq_ctrl;

  localparam bit FIXED =
`ifdef MULT_SEQ_CTRL_FIXED_PRIO_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] mul_a, mul_b;
  logic       mul_in_en, mul_s_en, mul_out_en;
  logic [7:0] mul_p;
  logic       res_valid, res_ready, res_id, busy;
  logic [7:0] res_data;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_in_en  (mul_in_en),
    .mul_s_en   (mul_s_en),
    .mul_out_en (mul_out_en),
    .mul_p      (mul_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  // Behavioural multiplier: input regs, product stage, output reg, each on its enable.
  logic [3:0] ma_q, mb_q;
  logic [7:0] ms_q, mp_q;
  always @(posedge clk) begin
    if (mul_in_en) begin
      ma_q <= mul_a;
      mb_q <= mul_b;
    end
    if (mul_s_en)   ms_q <= ma_q * mb_q;
    if (mul_out_en) mp_q <= ms_q;
  end
  assign mul_p = mp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [3:0] xa [4] = '{4'd15, 4'd0, 4'd1, 4'd8};
  logic [3:0] xb [4] = '{4'd15, 4'd9, 4'd15, 4'd2};
  logic [7:0] xp [4] = '{8'd225, 8'd0, 8'd15, 8'd16};

  logic [7:0] q_data [$];
  logic       q_id   [$];

  initial begin
    int  p, c0, c1, obs0, obs1, win;
    bit  stall, feed, exp_rv;

    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    res_ready = 1;
    rst = 1;
    #2 rst = 0;
    repeat (2) @(negedge clk);

    // Reset state, with a request pending that must not be acknowledged.
    req0_valid = 1; req0_a = 4'd7; req0_b = 4'd7;
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_in_en", mul_in_en, 0);
    check("rst_s_en", mul_s_en, 0);
    check("rst_out_en", mul_out_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    req0_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Single op 3x5 from requester 0.
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd5;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_in_en", mul_in_en, 1);
    check("single_mul_a", mul_a, 3);
    check("single_mul_b", mul_b, 5);
    @(negedge clk);
    req0_valid = 0;
    #1;
    check("single_s_en", mul_s_en, 1);
    check("single_in_en_off", mul_in_en, 0);
    check("single_busy", busy, 1);
    check("single_rv_t1", res_valid, 0);
    @(negedge clk);
    #1;
    check("single_out_en", mul_out_en, 1);
    check("single_rv_t2", res_valid, 0);
    @(negedge clk);
    #1;
    check("single_res_valid", res_valid, 1);
    check("single_res_data", res_data, 15);
    check("single_res_id", res_id, 0);
    @(negedge clk);
    #1;
    check("single_drained_rv", res_valid, 0);
    check("single_drained_busy", busy, 0);
    @(negedge clk);

    // Extremes, back to back, alternating lone requesters.
    for (int i = 0; i < 8; i++) begin
      req0_valid = 0; req1_valid = 0;
      if (i < 4) begin
        if (i % 2 == 0) begin
          req0_valid = 1; req0_a = xa[i]; req0_b = xb[i];
        end else begin
          req1_valid = 1; req1_a = xa[i]; req1_b = xb[i];
        end
      end
      #1;
      if (i < 4) check($sformatf("ext_ready_%0d", i), (i % 2 == 0) ? req0_ready : req1_ready, 1);
      if (i >= 3 && i <= 6) begin
        check($sformatf("ext_rv_%0d", i - 3), res_valid, 1);
        check($sformatf("ext_data_%0d", i - 3), res_data, xp[i-3]);
        check($sformatf("ext_id_%0d", i - 3), res_id, (i - 3) % 2);
      end
      if (i == 7) check("ext_rv_after", res_valid, 0);
      @(negedge clk);
    end

    // Reset with two ops in flight.
    req0_valid = 1; req0_a = 4'd4; req0_b = 4'd4;
    #1 check("mid_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_a = 4'd5; req1_b = 4'd5;
    #1 check("mid_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    #1 check("mid_busy_before", busy, 1);
    rst = 0; req0_valid = 1; req1_valid = 1;
    #1;
    check("mid_rv", res_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_ready0_rst", req0_ready, 0);
    check("mid_ready1_rst", req1_ready, 0);
    check("mid_in_en", mul_in_en, 0);
    check("mid_s_en", mul_s_en, 0);
    check("mid_out_en", mul_out_en, 0);
    @(negedge clk);
    rst = 1; req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("mid_no_stale_%0d", i), res_valid, 0);
      @(negedge clk);
    end
    req0_valid = 1; req0_a = 4'd6; req0_b = 4'd7;
    #1 check("recover_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("recover_rv", res_valid, 1);
    check("recover_data", res_data, 42);
    check("recover_id", res_id, 0);
    @(negedge clk);

    // Fresh reset so the tie pointer starts at requester 0.
    rst = 0;
    @(negedge clk);
    rst = 1;

    // Contention with a 4-cycle backpressure window on a full pipe.
    p = 0; c0 = 0; c1 = 0; obs0 = 0; obs1 = 0;
    for (int i = 0; i < 22; i++) begin
      stall  = (i >= 8 && i <= 11);
      feed   = (i < 16);
      exp_rv = (i >= 3 && i <= 18);
      res_ready  = !stall;
      req0_valid = feed; req1_valid = feed;
      req0_a = 4'(c0 + 1); req0_b = 4'd2;
      req1_a = 4'(c1 + 9); req1_b = 4'd3;
      #1;
      win = FIXED ? 0 : p;
      check($sformatf("cont_ready0_%0d", i), req0_ready, !stall && feed && win == 0);
      check($sformatf("cont_ready1_%0d", i), req1_ready, !stall && feed && win == 1);
      check($sformatf("cont_in_en_%0d", i), mul_in_en, !stall && feed);
      check($sformatf("cont_s_en_%0d", i), mul_s_en, !stall && i >= 1 && i <= 16);
      check($sformatf("cont_out_en_%0d", i), mul_out_en, !stall && i >= 2 && i <= 17);
      check($sformatf("cont_rv_%0d", i), res_valid, exp_rv);
      if (exp_rv && q_data.size() > 0) begin
        check($sformatf("cont_data_%0d", i), res_data, q_data[0]);
        check($sformatf("cont_id_%0d", i), res_id, q_id[0]);
        if (!stall) begin
          void'(q_data.pop_front());
          void'(q_id.pop_front());
        end
      end
      if (!stall && feed) begin
        if (win == 0) begin
          check($sformatf("cont_mul_a_%0d", i), mul_a, c0 + 1);
          q_data.push_back(8'((c0 + 1) * 2));
          q_id.push_back(1'b0);
          c0++;
        end else begin
          check($sformatf("cont_mul_a_%0d", i), mul_a, c1 + 9);
          q_data.push_back(8'((c1 + 9) * 3));
          q_id.push_back(1'b1);
          c1++;
        end
        if (!FIXED) p = 1 - win;
      end
      obs0 += int'(req0_ready);
      obs1 += int'(req1_ready);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    check("cont_all_delivered", q_data.size(), 0);
    check("cont_busy_end", busy, 0);
    check("cont_total_ops", obs0 + obs1, 12);
`ifdef MULT_SEQ_CTRL_FIXED_PRIO_EN
    check("fixed_req1_grants", obs1, 0);
`else
    check("rr_balance", (obs0 - obs1 <= 1) && (obs1 - obs0 <= 1), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
